// File: rtl/serial_compare_controller.sv
// Purpose : sequences a parallel a/b pair into an external MSB-first bit-serial
//           magnitude comparator and registers its gt/lt/eq verdict.
// Latency : done pulses WIDTH+2 edges after the start edge, or j+3 edges when
//           EARLY_EXIT=1 and bit j (0=MSB) is the first differing bit.
// Backpressure: none; start is only sampled in IDLE and dropped otherwise,
//           so a requester must hold or re-assert start after done.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start, a, b         request and operands, captured on the start edge
//   busy, done          busy in CLEAR/SHIFT/CAPTURE, done is a 1-cycle pulse
//   result_gt/lt/eq     registered verdict, held until next capture or reset
//   cmp_reset, cmp_x/y  drive the external comparator
//   cmp_gt, cmp_lt      sticky flags returned by the comparator

module serial_compare_controller #(
  parameter int WIDTH      = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             result_gt,
  output logic             result_lt,
  output logic             result_eq,
  output logic             cmp_reset,
  output logic             cmp_x,
  output logic             cmp_y,
  input  logic             cmp_gt,
  input  logic             cmp_lt
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;

  // Control strobes decoded from the current state.
  logic load_en;
  logic clear_en;
  logic shift_en;
  logic latch_en;
  logic decided;

  // The comparator flags lag the sampled bit by one cycle, so a decision seen
  // here belongs to a bit already shifted in; nothing is lost by leaving SHIFT.
  assign decided = EARLY_EXIT && (cmp_gt || cmp_lt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    cmp_x     = 1'b0;
    cmp_y     = 1'b0;
    cmp_reset = reset;
    load_en   = 1'b0;
    clear_en  = 1'b0;
    shift_en  = 1'b0;
    latch_en  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          load_en   = 1'b1;
          state_nxt = S_CLEAR;
        end
      end

      S_CLEAR: begin
        busy      = 1'b1;
        cmp_reset = 1'b1;
        clear_en  = 1'b1;
        state_nxt = S_SHIFT;
      end

      S_SHIFT: begin
        busy     = 1'b1;
        cmp_x    = sa[WIDTH-1];
        cmp_y    = sb[WIDTH-1];
        shift_en = 1'b1;
        // An early decision wins over the last-bit exit.
        if (decided) begin
          latch_en  = 1'b1;
          state_nxt = S_DONE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        // Flags now cover the final bit sampled on the previous edge.
        busy      = 1'b1;
        latch_en  = 1'b1;
        state_nxt = S_DONE;
      end

      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sa        <= '0;
      sb        <= '0;
      cnt       <= '0;
      result_gt <= 1'b0;
      result_lt <= 1'b0;
      result_eq <= 1'b0;
    end else begin
      if (load_en) begin
        sa <= a;
        sb <= b;
      end

      if (clear_en) begin
        cnt <= '0;
      end

      if (shift_en) begin
        sa <= {sa[WIDTH-2:0], 1'b0};
        sb <= {sb[WIDTH-2:0], 1'b0};
        // Hold at the last index instead of wrapping; SHIFT exits here anyway.
        if (cnt != CNT_LAST) begin
          cnt <= cnt + CW'(1);
        end
      end

      // Both flags high is latched as-is; eq stays low in that case.
      if (latch_en) begin
        result_gt <= cmp_gt;
        result_lt <= cmp_lt;
        result_eq <= ~cmp_gt & ~cmp_lt;
      end
    end
  end

endmodule

// File: tb/tb_serial_compare_controller.sv
module tb_serial_compare_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;

  // Instance 0: EARLY_EXIT=0, instance 1: EARLY_EXIT=1, same stimulus.
  logic busy0, done0, gt0, lt0, eq0, crst0, cx0, cy0;
  logic busy1, done1, gt1, lt1, eq1, crst1, cx1, cy1;
  logic fgt0, flt0, fgt1, flt1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_compare_controller #(.WIDTH(4), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy0), .done(done0),
    .result_gt(gt0), .result_lt(lt0), .result_eq(eq0),
    .cmp_reset(crst0), .cmp_x(cx0), .cmp_y(cy0),
    .cmp_gt(fgt0), .cmp_lt(flt0)
  );

  serial_compare_controller #(.WIDTH(4), .EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy1), .done(done1),
    .result_gt(gt1), .result_lt(lt1), .result_eq(eq1),
    .cmp_reset(crst1), .cmp_x(cx1), .cmp_y(cy1),
    .cmp_gt(fgt1), .cmp_lt(flt1)
  );

  // Behavioural bit-serial comparators: MSB first, sticky, sync clear.
  always @(posedge clk) begin
    if (crst0) begin
      fgt0 <= 1'b0;
      flt0 <= 1'b0;
    end else if (!fgt0 && !flt0) begin
      if (cx0 && !cy0) fgt0 <= 1'b1;
      else if (!cx0 && cy0) flt0 <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (crst1) begin
      fgt1 <= 1'b0;
      flt1 <= 1'b0;
    end else if (!fgt1 && !flt1) begin
      if (cx1 && !cy1) fgt1 <= 1'b1;
      else if (!cx1 && cy1) flt1 <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and watch both instances for 14 edges after the start
  // edge. Latency is the edge count after the start edge at which done is
  // first seen. With hold=1, start stays high through CLEAR..DONE.
  task automatic run_op(input string tag, input logic [3:0] av, input logic [3:0] bv,
                        input int lat0_exp, input int lat1_exp,
                        input logic [2:0] res_exp, input bit hold, input bit chk_seq);
    int lat0 = 0;
    int lat1 = 0;
    int nd0  = 0;
    int nd1  = 0;
    logic [3:0] xs = '0;
    logic [3:0] ys = '0;
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = hold;
    chk({tag, "_clear"}, {busy0, crst0, busy1, crst1}, 4'hF);
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (n <= 4) begin
        xs = {xs[2:0], cx0};
        ys = {ys[2:0], cy0};
      end
      if (done0) begin
        nd0++;
        if (lat0 == 0) lat0 = n;
      end
      if (done1) begin
        nd1++;
        if (lat1 == 0) lat1 = n;
      end
      start = hold && (n <= 6);
      a = ~av;
      b = ~bv;
    end
    chk({tag, "_lat0"}, lat0, lat0_exp);
    chk({tag, "_lat1"}, lat1, lat1_exp);
    chk({tag, "_ndone0"}, nd0, 1);
    chk({tag, "_ndone1"}, nd1, 1);
    chk({tag, "_res0"}, {gt0, lt0, eq0}, res_exp);
    chk({tag, "_res1"}, {gt1, lt1, eq1}, res_exp);
    chk({tag, "_idle"}, {busy0, busy1}, 2'b00);
    if (chk_seq) begin
      chk({tag, "_xseq"}, xs, 4'b0100);
      chk({tag, "_yseq"}, ys, 4'b0010);
    end
  endtask

  initial begin
    int nd;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    chk("rst_busy_done", {busy0, done0, busy1, done1}, 4'h0);
    chk("rst_res", {gt0, lt0, eq0, gt1, lt1, eq1}, 6'h00);
    chk("rst_xy", {cx0, cy0, cx1, cy1}, 4'h0);
    chk("rst_cmp_reset", {crst0, crst1}, 2'b11);
    reset = 1'b0;
    tick();
    chk("idle_cmp_reset", {crst0, crst1}, 2'b00);

    // {gt,lt,eq}
    run_op("gt", 4'b0100, 4'b0010, 6, 4, 3'b100, 1'b0, 1'b1);
    run_op("lt_lsb", 4'b0000, 4'b0001, 6, 6, 3'b010, 1'b0, 1'b0);
    run_op("eq_hold", 4'b1010, 4'b1010, 6, 6, 3'b001, 1'b1, 1'b0);

    // Abort at SHIFT cnt=1: start edge, CLEAR edge, first shift edge, then reset.
    a = 4'b1000;
    b = 4'b0111;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("abort_cmp_reset_in", {crst0, crst1}, 2'b11);
    tick();
    chk("abort_busy_done", {busy0, done0, busy1, done1}, 4'h0);
    chk("abort_res", {gt0, lt0, eq0, gt1, lt1, eq1}, 6'h00);
    chk("abort_cmp_reset_held", {crst0, crst1}, 2'b11);
    chk("abort_xy", {cx0, cy0, cx1, cy1}, 4'h0);
    reset = 1'b0;
    nd = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (done0 || done1 || busy0 || busy1) nd++;
    end
    chk("abort_quiet", nd, 0);

    run_op("lt_after_abort", 4'b0001, 4'b0010, 6, 5, 3'b010, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_compare_controller.md
Name: serial_compare_controller

Overview:
Sequencer that drives one bit-serial magnitude comparator (MSB-first, sticky greater/less flags) from parallel operands.
- Accepts WIDTH-bit operands a/b on a start pulse and clears the comparator.
- Shifts the operand bits into the comparator MSB-first, then captures the verdict and reports it with a one-cycle done pulse.
- Sits between a parallel requester and the serial comparator instance; the comparator is instantiated outside this block.

Parameters:
WIDTH, 4, operand width in bits (>=2)
EARLY_EXIT, 1, 1 = finish as soon as the comparator decides; 0 = always shift all WIDTH bits

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand driven to comparator x
b  input  WIDTH  operand driven to comparator y
busy  output  1  high in CLEAR, SHIFT, CAPTURE
done  output  1  one-cycle pulse, high in DONE
result_gt  output  1  registered verdict a>b
result_lt  output  1  registered verdict a<b
result_eq  output  1  registered verdict a==b
cmp_reset  output  1  comparator reset = reset OR (state==CLEAR)
cmp_x  output  1  current bit of a (MSB first)
cmp_y  output  1  current bit of b
cmp_gt  input  1  comparator sticky greater flag
cmp_lt  input  1  comparator sticky less flag

Behaviour:
- Comparator contract: it samples x/y on each rising clk edge. Its flags reflect all bits sampled so far, become valid the cycle after sampling, and are cleared by a synchronous cmp_reset.
- Reset (sync, at edge with reset=1):
  - state=IDLE, shift regs=0, cnt=0.
  - busy=0, done=0, result_gt/lt/eq=0.
  - cmp_x=cmp_y=0; cmp_reset=1 while reset is high.
- FSM states: IDLE, CLEAR, SHIFT, CAPTURE, DONE.
- IDLE:
  - On start=1 at edge E0, load sa<=a and sb<=b, then go to CLEAR.
  - a/b changes after E0 are ignored.
- CLEAR (one cycle):
  - cmp_reset=1, cmp_x=cmp_y=0.
  - At the next edge, go to SHIFT with cnt=0.
- SHIFT:
  - cmp_x=sa[WIDTH-1], cmp_y=sb[WIDTH-1].
  - Each edge: shift sa/sb left by one (zero fill), cnt<=cnt+1.
  - If cnt==WIDTH-1, go to CAPTURE.
  - If EARLY_EXIT=1 and (cmp_gt|cmp_lt)=1 at an edge: latch the flags into the result regs and go to DONE. This takes priority over the cnt rule.
- CAPTURE (one cycle):
  - cmp_x=cmp_y=0.
  - At the edge: result_gt<=cmp_gt, result_lt<=cmp_lt, result_eq<=~cmp_gt&~cmp_lt; go to DONE.
- DONE (one cycle): done=1, busy=0; next edge goes to IDLE.
- start in any state other than IDLE is ignored, including DONE. Back-to-back requests therefore need start held or re-asserted in IDLE.
- Latency without early exit: done is high in the cycle after edge E0+WIDTH+2 (WIDTH=4: 6 edges).
- Latency with early exit: first differing bit index j (0=MSB) gives done after E0+j+3 edges, capped at WIDTH+2.
- Result regs hold their value from the last capture until the next capture or reset.
- Both cmp flags high (illegal): latch as-is with result_eq=0; no recovery action.
- Reset mid-operation: abort to IDLE within the same edge, clear results, no done pulse, comparator cleared via cmp_reset.
- Width rules: cnt is clog2(WIDTH) bits; no wrap-around occurs because SHIFT exits at WIDTH-1.

Test Plan:
- WIDTH=4, EARLY_EXIT=0; reset, then start with a=0100, b=0010.
  - Required: cmp_x sequence 0,1,0,0 and cmp_y sequence 0,0,1,0.
  - Required: done 6 edges after start; result_gt=1, result_lt=0, result_eq=0.
- EARLY_EXIT=1, same operands.
  - Required: SHIFT leaves after bit 1 is decided; done 4 edges after start; result_gt=1.
- a=0000, b=0001 (either mode).
  - Required: done after 6 edges; result_lt=1, result_gt=0, result_eq=0.
- a=1010, b=1010.
  - Required: result_eq=1, gt=lt=0; done after 6 edges.
  - Required: a second start asserted while busy and during DONE is ignored (no extra done pulse).
- Start a=1000, b=0111; assert reset at SHIFT cnt=1.
  - Required: next cycle state is IDLE, busy=0, results 0, no done pulse, cmp_reset=1 during reset.
  - Required: a fresh start with a=0001, b=0010 then yields result_lt=1.
